// File: rtl/adder_share_pkg.sv
// Shared constants, FSM state type and the round-robin pick helper for adder_share_arbiter.
package adder_share_pkg;

  localparam int unsigned ADD_W   = 6;
  localparam int unsigned SUM_W   = 7;
  localparam int unsigned MAX_REQ = 4;

  typedef enum logic {IDLE, FULL} state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [1:0]         ptr,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = (32'(ptr) + i) % n;
      if (i < n && !p.found && valid[j[1:0]]) begin
        p.found = 1'b1;
        p.idx   = j[1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/adder_share_adder.sv
// The shared combinational adder: zero-extended 6+6 -> 7-bit sum.
module adder_share_adder
  import adder_share_pkg::*;
(
  input  logic [ADD_W-1:0] x,
  input  logic [ADD_W-1:0] y,
  output logic [SUM_W-1:0] s
);

  assign s = SUM_W'(x) + SUM_W'(y);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick with a registered priority pointer.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            update,
  output logic            found,
  output logic [IDW-1:0]  grant,
  output logic [IDW-1:0]  ptr
);

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    pick                  = rr_pick(valid_ext, 2'(ptr_q), NREQ);
    found                 = pick.found;
    grant                 = pick.idx[IDW-1:0];
    ptr_d                 = ptr_q;
    // Pointer moves past the winner only when the transfer actually happens.
    if (update) begin
      ptr_d = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one adder between NREQ valid/ready requesters, registered result.
// Optional perf counters enabled by defining ADDER_SHARE_PERF_EN.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned TAGW = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ADD_W-1:0]   req_x,
  input  logic [NREQ*ADD_W-1:0]   req_y,
  input  logic [NREQ*TAGW-1:0]    req_tag,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [TAGW-1:0]         resp_tag,
  output logic [SUM_W-1:0]        resp_sum
`ifdef ADDER_SHARE_PERF_EN
  ,
  output logic [NREQ*16-1:0]      perf_grants,
  output logic [15:0]             perf_stall
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [TAGW-1:0]  tag_q, tag_d;

  logic             free, found, accept;
  logic [IDW-1:0]   grant, rr_ptr;
  logic [ADD_W-1:0] add_x, add_y;
  logic [SUM_W-1:0] add_s;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid),
    .update(accept),
    .found (found),
    .grant (grant),
    .ptr   (rr_ptr)
  );

  assign free = (state_q == IDLE) | (resp_valid & resp_ready);

  always_comb begin
    req_ready = '0;
    if (rst_n && free && found) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept = |req_ready;
  assign add_x  = req_x[grant*ADD_W +: ADD_W];
  assign add_y  = req_y[grant*ADD_W +: ADD_W];

  adder_share_adder u_adder (
    .x(add_x),
    .y(add_y),
    .s(add_s)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    tag_d   = tag_q;
    // An accept in the same cycle as a drain overwrites the slot, so no bubble.
    if (accept) begin
      state_d = FULL;
      sum_d   = add_s;
      id_d    = grant;
      tag_d   = req_tag[grant*TAGW +: TAGW];
    end else if (resp_valid && resp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      id_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_sum   = sum_q;
  assign resp_id    = id_q;
  assign resp_tag   = tag_q;

`ifdef ADDER_SHARE_PERF_EN
  logic [NREQ-1:0][15:0] grant_cnt_q;
  logic [15:0]           stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept && grant == IDW'(i) && grant_cnt_q[i] != 16'hFFFF) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
      if (state_q == FULL && !resp_ready && |req_valid && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign perf_grants = grant_cnt_q;
  assign perf_stall  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (NREQ=2, TAGW=2).
module tb_adder_share_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TAGW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*6-1:0]   req_x, req_y;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                resp_valid, resp_ready;
  logic [0:0]          resp_id;
  logic [TAGW-1:0]     resp_tag;
  logic [6:0]          resp_sum;
`ifdef ADDER_SHARE_PERF_EN
  logic [NREQ*16-1:0]  perf_grants;
  logic [15:0]         perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(
    .NREQ(NREQ),
    .TAGW(TAGW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_tag   (req_tag),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_tag  (resp_tag),
    .resp_sum  (resp_sum)
`ifdef ADDER_SHARE_PERF_EN
    ,
    .perf_grants(perf_grants),
    .perf_stall (perf_stall)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] x, input logic [5:0] y,
                         input logic [1:0] tag);
    req_x[i*6 +: 6]         = x;
    req_y[i*6 +: 6]         = y;
    req_tag[i*TAGW +: TAGW] = tag;
  endtask

  task automatic check_resp(input string tag, input logic [6:0] sum, input logic id,
                            input logic [1:0] rtag);
    check_eq({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check_eq({tag, "_sum"}, 32'(resp_sum), 32'(sum));
    check_eq({tag, "_id"}, 32'(resp_id), 32'(id));
    check_eq({tag, "_tag"}, 32'(resp_tag), 32'(rtag));
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_x      = '0;
    req_y      = '0;
    req_tag    = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_sum", 32'(resp_sum), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);

    // Single request from requester 0
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 2'b01;
    set_req(0, 6'd5, 6'd9, 2'd2);
    #1 check_eq("single_grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    check_resp("single", 7'd14, 1'b0, 2'd2);
    @(negedge clk);
    check_eq("drain_valid", 32'(resp_valid), 32'd0);
    check_eq("drain_sum_hold", 32'(resp_sum), 32'd14);

    // Carry-out cases; pointer is now 1
    req_valid = 2'b10;
    set_req(1, 6'd63, 6'd63, 2'd1);
    #1 check_eq("carry_grant", 32'(req_ready), 32'b10);
    @(negedge clk);
    check_resp("max", 7'd126, 1'b1, 2'd1);
    req_valid = 2'b01;
    set_req(0, 6'd32, 6'd32, 2'd3);
    #1 check_eq("refill_grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    check_resp("bit6", 7'd64, 1'b0, 2'd3);

    // Fill with 0x2A, hold, then reset mid-FULL
    set_req(0, 6'd20, 6'd22, 2'd3);
    @(negedge clk);
    check_eq("full_2a", 32'(resp_sum), 32'h2A);
    req_valid  = 2'b00;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq("hold_2a", 32'(resp_sum), 32'h2A);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_sum", 32'(resp_sum), 32'd0);
    check_eq("midrst_tag", 32'(resp_tag), 32'd0);

    // Fairness: first grant must be 0 since reset clears the pointer
    @(negedge clk);
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    req_valid  = 2'b11;
    set_req(0, 6'd1, 6'd2, 2'd1);
    set_req(1, 6'd10, 6'd20, 2'd2);
    for (int k = 0; k < 6; k++) begin
      #1 check_eq($sformatf("fair_grant%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
      if (k > 0) begin
        if ((k - 1) % 2 == 0) check_resp($sformatf("fair_res%0d", k - 1), 7'd3, 1'b0, 2'd1);
        else check_resp($sformatf("fair_res%0d", k - 1), 7'd30, 1'b1, 2'd2);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    check_resp("fair_res5", 7'd30, 1'b1, 2'd2);
`ifdef ADDER_SHARE_PERF_EN
    check_eq("perf_grants1", 32'(perf_grants[31:16]), 32'd3);
`endif
    @(negedge clk);
    check_eq("fair_drain", 32'(resp_valid), 32'd0);

    // Backpressure; pointer is 0 here
    req_valid = 2'b01;
    set_req(0, 6'd7, 6'd8, 2'd1);
    @(negedge clk);
    check_resp("bp_first", 7'd15, 1'b0, 2'd1);
    resp_ready = 1'b0;
    req_valid  = 2'b11;
    set_req(1, 6'd4, 6'd4, 2'd2);
    for (int k = 0; k < 4; k++) begin
      #1 check_eq($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
      check_resp($sformatf("bp_hold%0d", k), 7'd15, 1'b0, 2'd1);
      @(negedge clk);
    end
`ifdef ADDER_SHARE_PERF_EN
    check_eq("perf_stall4", 32'(perf_stall), 32'd4);
`endif
    resp_ready = 1'b1;
    #1 check_eq("bp_release_grant", 32'(req_ready), 32'b10);
    @(negedge clk);
    check_resp("bp_nobubble", 7'd8, 1'b1, 2'd2);

`ifdef ADDER_SHARE_PERF_EN
    resp_ready = 1'b0;
    repeat (70000) @(negedge clk);
    check_eq("perf_stall_sat", 32'(perf_stall), 32'hFFFF);
`endif
    resp_ready = 1'b1;
    req_valid  = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Shares one combinational 6-bit adder (7-bit sum, s = x + y) between NREQ requesters. Each requester uses a valid/ready handshake. Arbitration is round-robin. The result is registered and routed back to the winning requester with its tag. The block sits between the operand sources and the adder, and is the only driver of the adder's x/y inputs.

Parameters:
NREQ, 2, number of requesters; legal range 2..4.
TAGW, 2, width of the per-request tag returned with the result.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
req_valid  in  NREQ  per-requester operand valid.
req_ready  out  NREQ  per-requester accept; one-hot or zero.
req_x  in  NREQ*6  operand x, requester i at bits [6i+5:6i].
req_y  in  NREQ*6  operand y, same packing.
req_tag  in  NREQ*TAGW  tag, same packing.
resp_valid  out  1  registered result valid.
resp_ready  in  1  consumer accept.
resp_id  out  $clog2(NREQ)  index of the requester owning the result.
resp_tag  out  TAGW  tag of the owning request.
resp_sum  out  7  registered sum; bit 6 is the carry-out.

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0, resp_sum=0, resp_id=0, resp_tag=0, rr_ptr=0, state=IDLE. req_ready is combinationally 0 while in reset.
- States:
  - IDLE: output register empty.
  - FULL: result held.
- Slot free condition: free = (state==IDLE) | (resp_valid & resp_ready).
- Grant:
  - Round-robin over req_valid, starting search at rr_ptr.
  - Grant is combinational: req_ready[g] = free & req_valid[g]; all other req_ready bits are 0.
  - No grant when no req_valid bit is set.
- Accept (req_valid[g] & req_ready[g]):
  - Adder inputs are driven with req_x[g] and req_y[g].
  - Next edge: resp_sum <= adder s, resp_id <= g, resp_tag <= req_tag[g], resp_valid <= 1, state <= FULL, rr_ptr <= (g+1) mod NREQ.
- Latency and throughput:
  - Latency is exactly 1 cycle from accept to resp_valid.
  - Back-to-back throughput is 1 result per cycle when resp_ready is held high.
- Drain without refill: resp_valid & resp_ready with no accept in the same cycle -> resp_valid <= 0, state <= IDLE. Other output registers hold their values.
- Simultaneous drain and accept: the new result replaces the old one; resp_valid stays 1 and no bubble is inserted.
- Hold in FULL with resp_ready=0:
  - All resp_* outputs are stable.
  - req_ready = 0.
  - rr_ptr is unchanged.
- rr_ptr advances only on an accepted transfer; stalled requesters never lose priority.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
- Arithmetic: the sum is zero-extended 6+6 -> 7 bits. There is no wrap: 63+63 = 126 (7'h7E).
- Requester input rules:
  - Requester inputs must be stable while req_valid=1 and req_ready=0.
  - Dropping req_valid before acceptance is legal: the request is simply not granted.
- Reset mid-operation: any held result is discarded and rr_ptr returns to 0. There is no partial output after rst_n deasserts.

Optional Feature:
ADDER_SHARE_PERF_EN.
- Defined:
  - Adds output perf_grants, width NREQ*16: one saturating 16-bit accepted-transfer counter per requester.
  - Adds output perf_stall, width 16: saturating count of cycles with state==FULL & ~resp_ready & |req_valid.
  - Counters reset to 0 asynchronously and hold at 16'hFFFF.
- Undefined: these ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package adder_share_pkg holds:
  - ADD_W=6 and SUM_W=7 constants.
  - state enum {IDLE, FULL}.
  - function rr_pick(valid, ptr) -> index plus a found flag.
- Sub-module rr_arbiter: combinational round-robin pick plus the registered rr_ptr, with an update input tied to the accept strobe.
- The existing adder is instanced once inside adder_share_arbiter.

Test Plan:
- Reset: rst_n low mid-FULL with resp_sum=7'h2A -> resp_valid=0 and resp_sum=0 immediately; rr_ptr=0 after release.
- Single request: req0 x=5, y=9, tag=2, resp_ready=1 -> resp_valid the next cycle, resp_sum=14, resp_id=0, resp_tag=2.
- Carry: x=63, y=63 -> resp_sum=126. Also x=32, y=32 -> resp_sum=64 (bit 6 set).
- Fairness: both requesters valid for 6 cycles with resp_ready=1 -> grant order 0,1,0,1,0,1; six results, one per cycle.
- Backpressure: resp_ready=0 for 4 cycles while FULL -> req_ready=0 and outputs stable. On resp_ready=1, the drain and the next accept occur in the same cycle with no bubble.
- Perf (ADDER_SHARE_PERF_EN): 3 grants to req1 plus 4 stall cycles -> perf_grants[1]=3 and perf_stall=4. A forced 70000 increments -> counter holds at 16'hFFFF.
